// File: rtl/seq_serializer.sv
// seq_serializer: ready/valid parallel word in, one registered serial bit per cycle out.
// Build option SER_PARITY_EN appends one even-parity bit after every word.
module seq_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             word_done
);
   localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state, state_n;
   logic [WIDTH-1:0] sreg, sreg_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             sout_n, valid_n, done_n;
   logic             final_c, accept_c;
`ifdef SER_PARITY_EN
   logic             par, par_n;
`endif

   // Bit that goes on the wire next from a (possibly shifted) word
   function automatic logic lead_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // The final serial cycle of a word reopens the input for a gapless follow-on word
`ifdef SER_PARITY_EN
   assign final_c = (state == PAR);
`else
   assign final_c = (state == SHIFT) && (cnt == LAST_IDX);
`endif
   assign din_ready = !rst && ((state == IDLE) || final_c);
   assign accept_c  = din_valid && din_ready;

   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      cnt_n   = cnt;
      sout_n  = 1'b0;
      valid_n = 1'b0;
      done_n  = 1'b0;
`ifdef SER_PARITY_EN
      par_n   = par;
`endif
      if (accept_c) begin
         state_n = SHIFT;
         sreg_n  = din;
         cnt_n   = '0;
         sout_n  = lead_bit(din);
         valid_n = 1'b1;
`ifdef SER_PARITY_EN
         par_n   = ^din;
`endif
      end else begin
         case (state)
            SHIFT: begin
               if (cnt != LAST_IDX) begin
                  cnt_n   = cnt + CW'(1);
                  sreg_n  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                  sout_n  = lead_bit(sreg_n);
                  valid_n = 1'b1;
`ifndef SER_PARITY_EN
                  done_n  = (cnt_n == LAST_IDX);
`endif
               end else begin
`ifdef SER_PARITY_EN
                  state_n = PAR;
                  sout_n  = par;
                  valid_n = 1'b1;
                  done_n  = 1'b1;
`else
                  state_n = IDLE;
`endif
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sreg       <= '0;
         cnt        <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         busy       <= 1'b0;
         word_done  <= 1'b0;
`ifdef SER_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sreg       <= sreg_n;
         cnt        <= cnt_n;
         sout       <= sout_n;
         sout_valid <= valid_n;
         busy       <= valid_n;
         word_done  <= done_n;
`ifdef SER_PARITY_EN
         par        <= par_n;
`endif
      end
   end
endmodule
